// File: rtl/lowent_codebook_engine.sv
// Low-entropy codebook engine: per-code nibble prefixes matched against a
// run-time loadable codebook, emitting codewords on a valid/ready stream,
// with an end-of-image flush that drains incomplete prefixes.
module lowent_codebook_engine #(
  parameter int unsigned NUM_CODES   = 16,
  parameter int unsigned SYM_W       = 4,
  parameter int unsigned MAX_SYMS    = 16,
  parameter int unsigned TABLE_DEPTH = 128,
  parameter int unsigned CW_W        = 21,
  parameter int unsigned CODE_W      = 4,
  localparam int unsigned PREFIX_W   = SYM_W * MAX_SYMS,
  localparam int unsigned ADDR_W     = $clog2(TABLE_DEPTH),
  localparam int unsigned LEN_W      = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  logic [ADDR_W-1:0]   cfg_addr_i,
  input  logic                cfg_en_i,
  input  logic                cfg_flush_i,
  input  logic [CODE_W-1:0]   cfg_code_i,
  input  logic [LEN_W-1:0]    cfg_ap_cnt_i,
  input  logic [PREFIX_W-1:0] cfg_ap_data_i,
  input  logic [LEN_W-1:0]    cfg_cw_len_i,
  input  logic [CW_W-1:0]     cfg_cw_data_i,
  input  logic                sym_valid_i,
  output logic                sym_ready_o,
  input  logic [CODE_W-1:0]   sym_code_i,
  input  logic [SYM_W-1:0]    sym_data_i,
  input  logic                flush_i,
  output logic                cw_valid_o,
  input  logic                cw_ready_i,
  output logic [CODE_W-1:0]   cw_code_o,
  output logic [LEN_W-1:0]    cw_len_o,
  output logic [CW_W-1:0]     cw_data_o,
  output logic                err_o,
  output logic                flush_done_o
);

  typedef struct packed {
    logic                en;
    logic                flush;
    logic [CODE_W-1:0]   code;
    logic [LEN_W-1:0]    ap_cnt;
    logic [PREFIX_W-1:0] ap_data;
    logic [LEN_W-1:0]    cw_len;
    logic [CW_W-1:0]     cw_data;
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, SCAN, DONE} state_t;

  state_t              state;
  entry_t              tbl     [TABLE_DEPTH];
  logic [LEN_W-1:0]    ap_cnt  [NUM_CODES];
  logic [PREFIX_W-1:0] ap_data [NUM_CODES];

  logic                s1_valid;
  logic [CODE_W-1:0]   s1_code;
  logic [SYM_W-1:0]    s1_sym;
  logic [CODE_W-1:0]   scan_c;

  logic                stall, out_free, sym_fire, s1_fire;
  logic                scan_mode, scan_busy, scan_step, scan_act;
  logic [LEN_W-1:0]    new_cnt;
  logic [PREFIX_W-1:0] new_data;
  logic [CODE_W-1:0]   key_code;
  logic [LEN_W-1:0]    key_cnt;
  logic [PREFIX_W-1:0] key_data;
  logic                hit;
  logic [LEN_W-1:0]    hit_len;
  logic [CW_W-1:0]     hit_cw;
  logic                overflow;

  // Handshake, append and search-key selection
  always_comb begin
    stall       = s1_valid && cw_valid_o && !cw_ready_i;
    out_free    = !cw_valid_o || cw_ready_i;
    sym_ready_o = !rst_i && (state == RUN) && !stall;
    sym_fire    = sym_valid_i && sym_ready_o;
    s1_fire     = s1_valid && !stall;
    new_cnt     = ap_cnt[s1_code] + LEN_W'(1);
    new_data    = (ap_data[s1_code] << SYM_W) | PREFIX_W'(s1_sym);
    overflow    = (new_cnt == LEN_W'(MAX_SYMS));
    scan_mode   = (state == SCAN);
    scan_busy   = (ap_cnt[scan_c] != '0);
    scan_step   = scan_mode && (!scan_busy || out_free);
    scan_act    = scan_mode && scan_busy && out_free;
    key_code    = scan_mode ? scan_c : s1_code;
    key_cnt     = scan_mode ? ap_cnt[scan_c] : new_cnt;
    key_data    = scan_mode ? ap_data[scan_c] : new_data;
  end

  // Shared parallel lookup; flush entries only during SCAN, lowest index wins
  always_comb begin
    hit     = 1'b0;
    hit_len = '0;
    hit_cw  = '0;
    for (int i = int'(TABLE_DEPTH) - 1; i >= 0; i--) begin
      if (tbl[i].en && (tbl[i].flush == scan_mode) && (tbl[i].code == key_code) &&
          (tbl[i].ap_cnt == key_cnt) && (tbl[i].ap_data == key_data)) begin
        hit     = 1'b1;
        hit_len = tbl[i].cw_len;
        hit_cw  = tbl[i].cw_data;
      end
    end
  end

  // Codebook table write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl <= '{default: '0};
    end else if (cfg_we_i) begin
      tbl[cfg_addr_i] <= '{en: cfg_en_i, flush: cfg_flush_i, code: cfg_code_i,
                           ap_cnt: cfg_ap_cnt_i, ap_data: cfg_ap_data_i,
                           cw_len: cfg_cw_len_i, cw_data: cfg_cw_data_i};
    end
  end

  // Stage 1 symbol register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_sym   <= '0;
    end else if (sym_fire) begin
      s1_valid <= 1'b1;
      s1_code  <= sym_code_i;
      s1_sym   <= sym_data_i;
    end else if (s1_fire) begin
      s1_valid <= 1'b0;
    end
  end

  // Per-code active prefixes; stage 1 reads them live, so back-to-back
  // symbols of one code always build on the freshly written result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ap_cnt  <= '{default: '0};
      ap_data <= '{default: '0};
    end else if (s1_fire) begin
      if (hit || overflow) begin
        ap_cnt[s1_code]  <= '0;
        ap_data[s1_code] <= '0;
      end else begin
        ap_cnt[s1_code]  <= new_cnt;
        ap_data[s1_code] <= new_data;
      end
    end else if (scan_act) begin
      ap_cnt[scan_c]  <= '0;
      ap_data[scan_c] <= '0;
    end
  end

  // Flush FSM and registered output stream
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      scan_c       <= '0;
      cw_valid_o   <= 1'b0;
      cw_code_o    <= '0;
      cw_len_o     <= '0;
      cw_data_o    <= '0;
      err_o        <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      err_o        <= 1'b0;
      flush_done_o <= 1'b0;
      if (cw_valid_o && cw_ready_i) cw_valid_o <= 1'b0;
      if ((s1_fire || scan_act) && hit) begin
        cw_valid_o <= 1'b1;
        cw_code_o  <= key_code;
        cw_len_o   <= hit_len;
        cw_data_o  <= hit_cw;
      end
      if ((s1_fire && !hit && overflow) || (scan_act && !hit)) err_o <= 1'b1;
      case (state)
        RUN:   if (flush_i) state <= DRAIN;
        DRAIN: if (!s1_valid) begin
          state  <= SCAN;
          scan_c <= '0;
        end
        SCAN:  if (scan_step) begin
          if (scan_c == CODE_W'(NUM_CODES - 1)) begin
            state        <= DONE;
            flush_done_o <= 1'b1;
          end else begin
            scan_c <= scan_c + CODE_W'(1);
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_lowent_codebook_engine.sv
// Directed bench for lowent_codebook_engine: table of back-to-back symbol
// vectors plus hand-written backpressure, overflow and flush sequences.
module tb_lowent_codebook_engine;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_we_i;
  logic [6:0]  cfg_addr_i;
  logic        cfg_en_i;
  logic        cfg_flush_i;
  logic [3:0]  cfg_code_i;
  logic [5:0]  cfg_ap_cnt_i;
  logic [63:0] cfg_ap_data_i;
  logic [5:0]  cfg_cw_len_i;
  logic [20:0] cfg_cw_data_i;
  logic        sym_valid_i;
  logic        sym_ready_o;
  logic [3:0]  sym_code_i;
  logic [3:0]  sym_data_i;
  logic        flush_i;
  logic        cw_valid_o;
  logic        cw_ready_i;
  logic [3:0]  cw_code_o;
  logic [5:0]  cw_len_o;
  logic [20:0] cw_data_o;
  logic        err_o;
  logic        flush_done_o;

  int n_chk = 0;
  int n_err = 0;

  lowent_codebook_engine dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_en_i(cfg_en_i),
    .cfg_flush_i(cfg_flush_i), .cfg_code_i(cfg_code_i), .cfg_ap_cnt_i(cfg_ap_cnt_i),
    .cfg_ap_data_i(cfg_ap_data_i), .cfg_cw_len_i(cfg_cw_len_i), .cfg_cw_data_i(cfg_cw_data_i),
    .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o), .sym_code_i(sym_code_i),
    .sym_data_i(sym_data_i), .flush_i(flush_i),
    .cw_valid_o(cw_valid_o), .cw_ready_i(cw_ready_i), .cw_code_o(cw_code_o),
    .cw_len_o(cw_len_o), .cw_data_o(cw_data_o), .err_o(err_o), .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [3:0]  code;
    logic [3:0]  sym;
    logic        ev;
    logic [3:0]  ecode;
    logic [5:0]  elen;
    logic [20:0] ecw;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(logic v, logic [3:0] c, logic [3:0] s, logic ev,
                              logic [3:0] ec, logic [5:0] el, logic [20:0] ecw, logic ee);
    vec_t r;
    r.v = v; r.code = c; r.sym = s; r.ev = ev;
    r.ecode = ec; r.elen = el; r.ecw = ecw; r.eerr = ee;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] s);
    sym_valid_i = v;
    sym_code_i  = c;
    sym_data_i  = s;
  endtask

  task automatic wr(input logic [6:0] a, input logic fl, input logic [3:0] c,
                    input logic [5:0] cnt, input logic [63:0] d, input logic [5:0] len,
                    input logic [20:0] cw);
    next_cycle();
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_en_i = 1'b1; cfg_flush_i = fl;
    cfg_code_i = c; cfg_ap_cnt_i = cnt; cfg_ap_data_i = d;
    cfg_cw_len_i = len; cfg_cw_data_i = cw;
    next_cycle();
    cfg_we_i = 1'b0;
  endtask

  // Pulse flush in cycle f; check outputs through f+19 against expected cycles
  task automatic do_flush(input int cw_at, input int err_at);
    next_cycle();
    flush_i = 1'b1;
    @(negedge clk_i);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_drain_ready", 64'(sym_ready_o), 64'd0);
    for (int k = 2; k <= 19; k++) begin
      next_cycle();
      @(negedge clk_i);
      chk("flush_cv", 64'(cw_valid_o), 64'(k == cw_at));
      if (k == cw_at) begin
        chk("flush_code", 64'(cw_code_o), 64'd1);
        chk("flush_len", 64'(cw_len_o), 64'd6);
        chk("flush_cw", 64'(cw_data_o), 64'b110001);
      end
      chk("flush_err", 64'(err_o), 64'(k == err_at));
      chk("flush_done", 64'(flush_done_o), 64'(k == 18));
      chk("flush_ready", 64'(sym_ready_o), 64'(k == 19));
    end
  endtask

  initial begin
    vec_t vecs[12];
    vecs[0]  = mk(1, 0, 3, 1, 0, 3, 21'b000, 0);
    vecs[1]  = mk(1, 0, 2, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1, 1, 0, 5, 21'b10100, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 3, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 1, 0, 8, 21'b11100001, 0);
    vecs[6]  = mk(1, 0, 2, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 5, 2, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, 1, 0, 5, 21'b10100, 0);
    vecs[9]  = mk(1, 5, 1, 1, 5, 4, 21'b0110, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_en_i = 1'b0; cfg_flush_i = 1'b0;
    cfg_code_i = '0; cfg_ap_cnt_i = '0; cfg_ap_data_i = '0; cfg_cw_len_i = '0;
    cfg_cw_data_i = '0; flush_i = 1'b0; cw_ready_i = 1'b1;
    drive(0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(sym_ready_o), 64'd0);
    chk("rst_cv", 64'(cw_valid_o), 64'd0);
    chk("rst_code", 64'(cw_code_o), 64'd0);
    chk("rst_len", 64'(cw_len_o), 64'd0);
    chk("rst_cw", 64'(cw_data_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_done", 64'(flush_done_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", 64'(sym_ready_o), 64'd1);

    wr(0, 0, 0, 1, 64'h3, 3, 21'b000);
    wr(1, 0, 0, 2, 64'h21, 5, 21'b10100);
    wr(2, 0, 0, 3, 64'h130, 8, 21'b11100001);
    wr(3, 0, 5, 2, 64'h21, 4, 21'b0110);
    wr(4, 0, 7, 1, 64'h9, 7, 21'h55);
    wr(9, 0, 7, 1, 64'h9, 9, 21'h1FF);
    wr(20, 1, 1, 1, 64'h2, 6, 21'b110001);

    // Back-to-back vector table: vector i drives cycle i, checked at i+2
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      if (i < 12) drive(vecs[i].v, vecs[i].code, vecs[i].sym);
      else drive(0, 0, 0);
      @(negedge clk_i);
      if (i < 12) chk("vec_ready", 64'(sym_ready_o), 64'd1);
      if (i >= 2) begin
        chk($sformatf("vec%0d_cv", i - 2), 64'(cw_valid_o), 64'(vecs[i-2].ev));
        chk($sformatf("vec%0d_err", i - 2), 64'(err_o), 64'(vecs[i-2].eerr));
        if (vecs[i-2].ev) begin
          chk($sformatf("vec%0d_code", i - 2), 64'(cw_code_o), 64'(vecs[i-2].ecode));
          chk($sformatf("vec%0d_len", i - 2), 64'(cw_len_o), 64'(vecs[i-2].elen));
          chk($sformatf("vec%0d_cw", i - 2), 64'(cw_data_o), 64'(vecs[i-2].ecw));
        end
      end
    end

    // Backpressure with duplicate entries at 4 and 9: index 4 must win
    next_cycle();
    cw_ready_i = 1'b0;
    drive(1, 7, 9);
    next_cycle();
    drive(1, 7, 9);
    @(negedge clk_i);
    chk("bp_accept2_ready", 64'(sym_ready_o), 64'd1);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      drive(0, 0, 0);
      @(negedge clk_i);
      chk("bp_hold_cv", 64'(cw_valid_o), 64'd1);
      chk("bp_hold_code", 64'(cw_code_o), 64'd7);
      chk("bp_hold_len", 64'(cw_len_o), 64'd7);
      chk("bp_hold_cw", 64'(cw_data_o), 64'h55);
      chk("bp_stall_ready", 64'(sym_ready_o), 64'd0);
    end
    next_cycle();
    cw_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", 64'(sym_ready_o), 64'd1);
    next_cycle();
    @(negedge clk_i);
    chk("bp_reload_cv", 64'(cw_valid_o), 64'd1);
    chk("bp_reload_len", 64'(cw_len_o), 64'd7);
    chk("bp_reload_cw", 64'(cw_data_o), 64'h55);
    next_cycle();
    @(negedge clk_i);
    chk("bp_empty_cv", 64'(cw_valid_o), 64'd0);

    // Overflow: 16 unmatched symbols of code 2
    for (int k = 0; k < 18; k++) begin
      next_cycle();
      if (k < 16) drive(1, 2, 4'hA);
      else drive(0, 0, 0);
      @(negedge clk_i);
      if (k >= 2) begin
        chk("ovf_err", 64'(err_o), 64'(k == 17));
        chk("ovf_cv", 64'(cw_valid_o), 64'd0);
      end
    end
    // Prefix cleared: a single A now matches a 1-symbol entry
    wr(30, 0, 2, 1, 64'hA, 2, 21'b11);
    next_cycle();
    drive(1, 2, 4'hA);
    next_cycle();
    drive(0, 0, 0);
    next_cycle();
    @(negedge clk_i);
    chk("ovf_clear_cv", 64'(cw_valid_o), 64'd1);
    chk("ovf_clear_code", 64'(cw_code_o), 64'd2);
    chk("ovf_clear_len", 64'(cw_len_o), 64'd2);

    // Leave code1 = 'h2 and code3 = 'h7; flush entry must not match normally
    next_cycle();
    drive(1, 1, 2);
    next_cycle();
    drive(1, 3, 7);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(0, 0, 0);
      @(negedge clk_i);
      if (k > 0) begin
        chk("pre_flush_cv", 64'(cw_valid_o), 64'd0);
        chk("pre_flush_err", 64'(err_o), 64'd0);
      end
    end

    do_flush(4, 6);
    // Second flush: every prefix must now be empty
    do_flush(-1, -1);

    // Symbol path alive after flush
    next_cycle();
    drive(1, 0, 3);
    next_cycle();
    drive(0, 0, 0);
    next_cycle();
    @(negedge clk_i);
    chk("post_flush_cv", 64'(cw_valid_o), 64'd1);
    chk("post_flush_len", 64'(cw_len_o), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lowent_codebook_engine.md
# lowent_codebook_engine

- Parametrised, sequential low-entropy codebook engine for the hybrid entropy coder.
- Keeps one active prefix of nibble symbols per low-entropy code and appends each incoming symbol to that code's prefix.
- Compares the prefix against a run-time loadable codebook table and emits the matching codeword through a valid/ready stream.
- Drives end-of-image flush codewords for prefixes left incomplete. It sits between the low-entropy symbol mapper and the bit packer.

## Interface
Parameters:
- NUM_CODES, 16, number of low-entropy codes (independent active prefixes)
- SYM_W, 4, symbol width
- MAX_SYMS, 16, maximum prefix length in symbols; PREFIX_W = SYM_W*MAX_SYMS (64)
- TABLE_DEPTH, 128, codebook entries
- CW_W, 21, codeword width; length fields are 6 bits
- CODE_W, 4, code-index width (>= clog2(NUM_CODES)); ADDR_W = clog2(TABLE_DEPTH)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. Synchronous, active-high.
- cfg_we_i  in  1  write table entry
- cfg_addr_i  in  ADDR_W  entry index
- cfg_en_i  in  1  entry enable
- cfg_flush_i  in  1  entry is a flush entry
- cfg_code_i  in  CODE_W  code index of entry
- cfg_ap_cnt_i  in  6  prefix length in symbols
- cfg_ap_data_i  in  PREFIX_W  prefix symbols, right-justified, unused MSBs zero
- cfg_cw_len_i  in  6  codeword length
- cfg_cw_data_i  in  CW_W  codeword, right-justified
- sym_valid_i / sym_ready_o  in/out  1  symbol handshake
- sym_code_i  in  CODE_W  code the symbol belongs to
- sym_data_i  in  SYM_W  symbol
- flush_i  in  1  single-cycle flush request
- cw_valid_o / cw_ready_i  out/in  1  codeword handshake
- cw_code_o  out  CODE_W  code of emitted codeword
- cw_len_o  out  6  codeword length
- cw_data_o  out  CW_W  codeword
- err_o  out  1  one-cycle pulse: prefix overflow or missing flush entry
- flush_done_o  out  1  one-cycle pulse: flush completed

## Operation
Prefix storage and table:
- Per code c: ap_cnt[c] (6 b), ap_data[c] (PREFIX_W).
- The table is a register array; every entry resets to en=0.
- A table write lands at the clock edge. A compare in the same cycle uses the old contents.

Symbol path:
- Appending a symbol: new_cnt = cnt+1; new_data = (data << SYM_W) | sym. The first symbol ends up in the most significant occupied nibble (prefix 1,3,0 = 'h130).
- Stage 1 compares {code, new_cnt, new_data} in parallel against all entries with en=1 and flush=0.
- Multiple hits: the lowest index wins.
- Hit: load the output register with {code, len, cw} and clear the prefix.
- Miss with new_cnt < MAX_SYMS: store the new prefix.
- Miss with new_cnt == MAX_SYMS: pulse err_o, clear the prefix, emit nothing.
- Forwarding: if stage 1 holds code c when a new symbol of code c is accepted, the new symbol builds on stage 1's result (cleared or new prefix), never on the stale register.

FSM states:
- RUN: symbols accepted.
- DRAIN: wait for stage 1 to empty.
- SCAN: one code per cycle, c = 0..NUM_CODES-1.
- DONE: pulse flush_done_o, return to RUN.

FSM transitions and rules:
- RUN -> DRAIN on flush_i. A symbol accepted in the same cycle as flush_i is processed before the flush.
- SCAN, empty prefix: skip it in one cycle.
- SCAN, non-empty prefix: compare {c, cnt, data} against en=1, flush=1 entries.
  - Hit: emit the codeword and clear the prefix.
  - Miss: pulse err_o and clear the prefix.
- SCAN advances only when the output register can accept.
- flush_i outside RUN is ignored.

## Timing
- Reset values: all prefixes empty; state RUN; stage 1 empty; cw_valid_o, cw_code_o, cw_len_o, cw_data_o, err_o, flush_done_o = 0.
- sym_ready_o = 0 while rst_i is high.
- sym_ready_o = (state==RUN) && !stall, where stall = s1_valid && cw_valid_o && !cw_ready_i. It depends combinationally on cw_ready_i.
- Latency: a symbol accepted in cycle t gives its codeword on cw_*_o in cycle t+2. Its prefix update is visible from cycle t+2.
- Throughput: one symbol per cycle with cw_ready_i held high, including back-to-back symbols of the same code.
- Output register:
  - Holds its value while cw_valid_o && !cw_ready_i.
  - Reloads on the same edge it is consumed.
  - cw_* are stable while valid and not ready.
- err_o is asserted in cycle t+2 of the offending symbol, aligned with when a codeword would have appeared.
- Flush:
  - flush_i in cycle t moves to DRAIN at t+1.
  - SCAN lasts NUM_CODES cycles plus stall cycles.
  - flush_done_o is asserted in the cycle after the last flush codeword is loaded.
- Reset mid-operation: everything returns to reset values on the next edge. Partial prefixes and a pending codeword are discarded.

## Test plan
- Basic 1- and 2-symbol codes:
  - Load entry0 = {code0, cnt1, 'h3, len3, 'b000} and entry1 = {code0, cnt2, 'h21, len5, 'b10100}.
  - Send code0 symbols 3, then 2, 1 back-to-back.
  - Expect cw (3,'b000) at t+2, then (5,'b10100) with nothing for the first symbol of 2,1.
- 3-symbol code: load {code0, cnt3, 'h130, len8, 'b11100001}; send 1,3,0 → a single codeword at cycle t_last+2; ap_cnt[0] = 0 afterwards.
- Interleaved codes: code0 sends 2, code5 sends 2, code0 sends 1, code5 sends 1, each pair having its own entry → two codewords, each tagged with its correct cw_code_o.
- Backpressure and duplicate match:
  - Two identical entries at indices 4 and 9 with different cw; cw_ready_i low for 5 cycles.
  - Expect the index-4 codeword, cw_* held stable, and sym_ready_o low during the stall.
- Overflow: with no entries matching, send MAX_SYMS=16 symbols of code2 → err_o pulses once at t16+2, no codeword, prefix cleared.
- Flush:
  - Code1 is left holding 'h2 (cnt1) with a flush entry {code1, cnt1, 'h2, len6, 'b110001}; code3 is left holding 'h7 with no flush entry.
  - Pulse flush_i.
  - Expect codeword (6,'b110001, code1), then err_o, then flush_done_o; all prefixes empty; sym_ready_o back to 1.
